// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- pixel/line counters and registered sync/colour stage for a
// VGA-style raster display.
//
// Ports
//   clk        in   1   system clock, all state changes on the rising edge
//   resetn     in   1   synchronous active-low reset, wins over ce
//   ce         in   1   pixel-tick enable; nothing advances while low
//   colour_in  in  12   renderer colour, combinational in x/y
//   x, y       out 10   current h/v counters (no pipeline delay)
//   video_on   out  1   x/y inside the visible area (combinational)
//   hsync      out  1   active-low hsync, registered to line up with rgb
//   vsync      out  1   active-low vsync, registered to line up with rgb
//   rgb        out 12   registered colour, forced to 0 while blanked
//   frame_tick out  1   one-clk pulse on the last tick of a frame
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ce,
  input  logic [11:0] colour_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt, v_cnt;
  logic       h_last, v_last;
  logic       hs_raw, vs_raw;

  assign h_last = (h_cnt == H_MAX);
  assign v_last = (v_cnt == V_MAX);

  // Counters: h wraps every line, v steps only on the last pixel of a line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      h_cnt <= h_last ? '0 : h_cnt + 10'd1;
      if (h_last)
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
    end
  end

  assign x        = h_cnt;
  assign y        = v_cnt;
  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw   = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_raw   = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  // Output stage: one ce-tick behind the counters. Syncs go through the same
  // register as rgb so the monitor sees them aligned with the pixel data.
  // Reset parks syncs inactive so a restart never emits a truncated pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (ce) begin
      rgb   <= video_on ? colour_in : 12'h000;
      hsync <= ~hs_raw;
      vsync <= ~vs_raw;
    end
  end

  // Combinational so it covers exactly the clk in which the final tick is
  // taken; gated by resetn so it reads 0 whenever reset is applied.
  assign frame_tick = resetn & ce & h_last & v_last;

endmodule
